// File: rtl/uart_service.sv
// Byte-command interpreter between a UART byte interface and a FIFO read/write port.
// Optional macro UART_SERVICE_ERR_REPLY_EN: reply ERR_CODE to unknown commands.
module uart_service #(
  parameter logic [7:0] CMD_WRITE = 8'h30,
  parameter logic [7:0] CMD_READ  = 8'h31,
  parameter logic [7:0] CMD_PEEK  = 8'h32,
  parameter logic [7:0] ERR_CODE  = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_symbol,
  input  logic       rx_valid,
  input  logic [7:0] value_to_read,
  output logic [7:0] tx_symbol,
  output logic       tx_start,
  output logic [7:0] value_to_write,
  output logic       enable_write,
  output logic       enable_read,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_DATA  = 3'd1,
    WRITE     = 3'd2,
    READ_REQ  = 3'd3,
    READ_WAIT = 3'd4,
    SEND      = 3'd5
  } state_t;

  state_t     state, state_nx;
  logic [7:0] instruction, instruction_nx;
  logic [7:0] data, data_nx;
  logic [7:0] tx_symbol_nx;

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte arriving
  // outside IDLE/GET_DATA is dropped. All strobes are one-cycle, registered from next state.
  always_comb begin
    state_nx       = state;
    instruction_nx = instruction;
    data_nx        = data;
    tx_symbol_nx   = tx_symbol;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          instruction_nx = rx_symbol;
          if (rx_symbol == CMD_WRITE) begin
            state_nx = GET_DATA;
          end else if (rx_symbol == CMD_READ) begin
            state_nx = READ_REQ;
          end else if (rx_symbol == CMD_PEEK) begin
            state_nx     = SEND;
            tx_symbol_nx = data;
          end else begin
`ifdef UART_SERVICE_ERR_REPLY_EN
            state_nx     = SEND;
            tx_symbol_nx = ERR_CODE;
`else
            state_nx     = IDLE;
`endif
          end
        end
      end
      GET_DATA: begin
        // Any byte here is payload, even one that looks like a command.
        if (rx_valid) begin
          data_nx  = rx_symbol;
          state_nx = WRITE;
        end
      end
      WRITE:     state_nx = IDLE;
      READ_REQ:  state_nx = READ_WAIT;
      READ_WAIT: begin
        tx_symbol_nx = value_to_read;
        state_nx     = SEND;
      end
      SEND:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      instruction  <= 8'h00;
      data         <= 8'h00;
      tx_symbol    <= 8'h00;
      tx_start     <= 1'b0;
      enable_write <= 1'b0;
      enable_read  <= 1'b0;
    end else begin
      state        <= state_nx;
      instruction  <= instruction_nx;
      data         <= data_nx;
      tx_symbol    <= tx_symbol_nx;
      tx_start     <= (state_nx == SEND);
      enable_write <= (state_nx == WRITE);
      enable_read  <= (state_nx == READ_REQ);
    end
  end

  assign value_to_write = data;
  assign fsm_state      = state;

endmodule

// File: tb/tb_uart_service.sv
// Bench for uart_service: directed literal cases plus randomized command stream
// checked every cycle against a transaction-level model of strobes and held values.
module tb_uart_service;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_symbol;
  logic       rx_valid;
  logic [7:0] value_to_read;
  logic [7:0] tx_symbol;
  logic       tx_start;
  logic [7:0] value_to_write;
  logic       enable_write;
  logic       enable_read;
  logic [2:0] fsm_state;

  uart_service dut (
    .clk(clk), .rst(rst), .rx_symbol(rx_symbol), .rx_valid(rx_valid),
    .value_to_read(value_to_read), .tx_symbol(tx_symbol), .tx_start(tx_start),
    .value_to_write(value_to_write), .enable_write(enable_write),
    .enable_read(enable_read), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: expected strobe events keyed by the cycle they must be visible in.
  typedef struct {
    int         at;
    bit         lazy;  // tx symbol comes from value_to_read presented the cycle before
    logic [7:0] val;
  } ev_t;
  ev_t        we_q[$];
  ev_t        re_q[$];
  ev_t        exp_q[$];
  logic [7:0] vtr_hist[int];
  bit         m_expect_data;
  logic [7:0] m_data;
  int         m_busy_until;
  logic [7:0] exp_vtw;
  logic [7:0] exp_txs;

  function automatic void model_reset();
    m_expect_data = 1'b0;
    m_data        = 8'h00;
    m_busy_until  = -1;
    exp_vtw       = 8'h00;
    exp_txs       = 8'h00;
    we_q.delete();
    re_q.delete();
    exp_q.delete();
  endfunction

  // Byte sampled by the clock edge that starts cycle e; results are visible in cycle e.
  function automatic void model_rx(input logic [7:0] b, input int e);
    if (e <= m_busy_until) return;
    if (m_expect_data) begin
      m_expect_data = 1'b0;
      m_data        = b;
      we_q.push_back('{e, 1'b0, b});
      m_busy_until  = e + 1;
    end else if (b == 8'h30) begin
      m_expect_data = 1'b1;
    end else if (b == 8'h31) begin
      re_q.push_back('{e, 1'b0, 8'h00});
      exp_q.push_back('{e + 2, 1'b1, 8'h00});
      m_busy_until = e + 3;
    end else if (b == 8'h32) begin
      exp_q.push_back('{e, 1'b0, m_data});
      m_busy_until = e + 1;
    end else begin
`ifdef UART_SERVICE_ERR_REPLY_EN
      exp_q.push_back('{e, 1'b0, 8'h3F});
      m_busy_until = e + 1;
`endif
    end
  endfunction

  // value_to_read driver: random or fixed, with history for the model
  bit         vtr_use_fixed = 1'b0;
  logic [7:0] vtr_fixed = 8'h00;
  initial begin
    value_to_read = 8'h00;
    forever begin
      @(negedge clk);
      value_to_read = vtr_use_fixed ? vtr_fixed : 8'($urandom);
      vtr_hist[cyc] = value_to_read;
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    bit we, re, tx;
    #1;
    we = 1'b0; re = 1'b0; tx = 1'b0;
    if (we_q.size() > 0 && we_q[0].at == cyc) begin
      we = 1'b1; exp_vtw = we_q[0].val; void'(we_q.pop_front());
    end
    if (re_q.size() > 0 && re_q[0].at == cyc) begin
      re = 1'b1; void'(re_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      tx = 1'b1;
      exp_txs = exp_q[0].lazy ? vtr_hist[cyc - 1] : exp_q[0].val;
      void'(exp_q.pop_front());
    end
    check("enable_write",   {7'b0, enable_write}, {7'b0, we});
    check("enable_read",    {7'b0, enable_read},  {7'b0, re});
    check("tx_start",       {7'b0, tx_start},     {7'b0, tx});
    check("value_to_write", value_to_write,       exp_vtw);
    check("tx_symbol",      tx_symbol,            exp_txs);
  end

  // driver tasks; all called at a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_symbol = b;
    rx_valid  = 1'b1;
    model_rx(b, cyc + 1);
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_symbol = 8'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_tx_start",       {7'b0, tx_start},     8'h00);
    check("rst_enable_write",   {7'b0, enable_write}, 8'h00);
    check("rst_enable_read",    {7'b0, enable_read},  8'h00);
    check("rst_tx_symbol",      tx_symbol,            8'h00);
    check("rst_value_to_write", value_to_write,       8'h00);
    check("rst_fsm_state",      {5'b0, fsm_state},    8'h00);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 8'h30;
    if (r < 5) return 8'h31;
    if (r < 7) return 8'h32;
    return 8'($urandom);
  endfunction

  initial begin
    rst       = 1'b0;
    rx_valid  = 1'b0;
    rx_symbol = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    check("init_fsm_state", {5'b0, fsm_state}, 8'h00);
    check("init_tx_symbol", tx_symbol, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    vtr_use_fixed = 1'b1;
    vtr_fixed     = 8'hEE;
    repeat (2) @(negedge clk);

    // write 0xA0
    send_byte(8'h30, 3);
    send_byte(8'hA0, 1);
    #2;
    check("wr_strobe", {7'b0, enable_write}, 8'h01);
    check("wr_value",  value_to_write, 8'hA0);
    check("wr_no_rd",  {7'b0, enable_read}, 8'h00);
    @(negedge clk); repeat (3) @(negedge clk);

    // peek returns the last written byte
    send_byte(8'h32, 1);
    #2;
    check("peek_start",  {7'b0, tx_start}, 8'h01);
    check("peek_symbol", tx_symbol, 8'hA0);
    @(negedge clk); repeat (3) @(negedge clk);

    // read: strobe at N+1, tx at N+3
    send_byte(8'h31, 1);
    #2;
    check("rd_strobe", {7'b0, enable_read}, 8'h01);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rd_start",  {7'b0, tx_start}, 8'h01);
    check("rd_symbol", tx_symbol, 8'hEE);
    @(negedge clk); repeat (3) @(negedge clk);

    // unknown command
    send_byte(8'hBB, 1);
    #2;
`ifdef UART_SERVICE_ERR_REPLY_EN
    check("unk_start",  {7'b0, tx_start}, 8'h01);
    check("unk_symbol", tx_symbol, 8'h3F);
`else
    check("unk_start", {7'b0, tx_start}, 8'h00);
    check("unk_state", {5'b0, fsm_state}, 8'h00);
`endif
    @(negedge clk); repeat (3) @(negedge clk);

    // command code as write payload
    send_byte(8'h30, 1);
    send_byte(8'h31, 1);
    #2;
    check("cmd_as_data_strobe", {7'b0, enable_write}, 8'h01);
    check("cmd_as_data_value",  value_to_write, 8'h31);
    check("cmd_as_data_no_rd",  {7'b0, enable_read}, 8'h00);
    @(negedge clk); repeat (4) @(negedge clk);

    // async reset while waiting for a data byte
    send_byte(8'h30, 2);
    #1;
    check("pre_rst_state", {5'b0, fsm_state}, 8'h01);
    @(negedge clk);
    do_reset();

    vtr_use_fixed = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset();
      else send_byte(pick_byte(), $urandom_range(1, 6));
    end
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
